// File: rtl/image_sender_pkg.sv
// Shared types, colour constants and pixels-per-word helper for the image window sender.
package image_sender_pkg;

  typedef enum logic [1:0] {
    MODE_MONO8  = 2'd0,
    MODE_RGBX32 = 2'd1,
    MODE_MONO1  = 2'd2,
    MODE_RSVD   = 2'd3
  } pixel_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1
  } sender_state_e;

  localparam logic [23:0] BG_COLOR_DEF        = 24'hFF0000;
  localparam logic [23:0] UNDERFLOW_COLOR_DEF = 24'h00FF00;
  localparam logic [23:0] IDLE_COLOR_DEF      = 24'h0000FF;
  localparam logic [23:0] RESET_COLOR         = 24'hFFFFFF;

  // Number of pixels packed in one stream word for a given mode.
  function automatic int unsigned ppw(input pixel_mode_e mode, input int unsigned data_width);
    case (mode)
      MODE_MONO8:  ppw = data_width / 8;
      MODE_RGBX32: ppw = data_width / 32;
      MODE_MONO1:  ppw = data_width;
      default:     ppw = 1;
    endcase
  endfunction

endpackage

// File: rtl/pixel_unpacker.sv
// Holds the current stream word and hands out one pixel per window cycle.
// The slot index advances on every window cycle, data or not, so a late word
// only supplies the pixels from the current slot onwards.
module pixel_unpacker
  import image_sender_pkg::*;
#(
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk_pixel,
  input  logic                  image_sender_reset_n,
  input  logic                  active,
  input  logic                  consume,
  input  logic                  flush,
  input  pixel_mode_e           mode,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [23:0]           pixel,
  output logic                  underflow
);

  localparam int IDX_W = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] cur_word;
  logic                  cur_valid;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      last_idx;
  logic                  at_last;
  logic                  load;
  logic [7:0]            byte_sel;
  logic [23:0]           rgb_sel;

  assign last_idx  = IDX_W'(ppw(mode, DATA_WIDTH) - 1);
  assign at_last   = (idx == last_idx);
  assign s_ready   = active && (!cur_valid || (consume && at_last));
  assign load      = s_valid && s_ready;
  assign underflow = consume && !cur_valid;

  // Slot selection: byte lane for MONO8, 32-bit lane (RGB in low 24 bits) for RGBX32
  always_comb begin
    byte_sel = '0;
    rgb_sel  = '0;
    for (int i = 0; i < DATA_WIDTH / 8; i++) begin
      if (idx == IDX_W'(i)) byte_sel = cur_word[i*8 +: 8];
    end
    for (int i = 0; i < DATA_WIDTH / 32; i++) begin
      if (idx == IDX_W'(i)) rgb_sel = cur_word[i*32 +: 24];
    end
  end

  // Mode mux from the selected slot to a 24-bit colour
  always_comb begin
    pixel = 24'h000000;
    case (mode)
      MODE_MONO8:  pixel = {3{byte_sel}};
      MODE_RGBX32: pixel = rgb_sel;
      MODE_MONO1:  pixel = cur_word[idx] ? 24'hFFFFFF : 24'h000000;
      default:     pixel = 24'h000000;
    endcase
  end

  // Word-valid and slot index; a boundary flush wins over a same-cycle load
  always_ff @(posedge clk_pixel) begin
    if (!image_sender_reset_n) begin
      cur_valid <= 1'b0;
      idx       <= '0;
    end else if (flush) begin
      cur_valid <= 1'b0;
      idx       <= '0;
    end else begin
      if (consume) idx <= at_last ? '0 : idx + IDX_W'(1);
      if (load) cur_valid <= 1'b1;
      else if (consume && at_last) cur_valid <= 1'b0;
    end
  end

  // Word storage; qualified by cur_valid, so it needs no reset
  always_ff @(posedge clk_pixel) begin
    if (load) cur_word <= s_data;
  end

endmodule

// File: rtl/image_window_sender.sv
// Pixel sender between the image FIFOs and the HDMI timing generator.
// Drives unpacked stream pixels inside a run-time window, background elsewhere,
// and does per-frame handshaking and error accounting at a boundary placed
// IMAGE_CHANGE_TIME lines before the end of the frame.
module image_window_sender
  import image_sender_pkg::*;
#(
  parameter int          FRAME_WIDTH       = 2200,
  parameter int          FRAME_HEIGHT      = 1125,
  parameter int          SCREEN_WIDTH      = 1920,
  parameter int          SCREEN_HEIGHT     = 1080,
  parameter int          BIT_WIDTH         = 12,
  parameter int          BIT_HEIGHT        = 11,
  parameter int          DATA_WIDTH        = 128,
  parameter int          IMAGE_CHANGE_TIME = 40,
  parameter logic [23:0] BG_COLOR          = BG_COLOR_DEF,
  parameter logic [23:0] UNDERFLOW_COLOR   = UNDERFLOW_COLOR_DEF,
  parameter logic [23:0] IDLE_COLOR        = IDLE_COLOR_DEF
) (
  input  logic                  clk_pixel,
  input  logic                  image_sender_reset_n,
  input  logic                  enable,
  input  logic                  image_change,
  input  logic [1:0]            cfg_mode,
  input  logic [BIT_WIDTH-1:0]  cfg_x0,
  input  logic [BIT_WIDTH-1:0]  cfg_width,
  input  logic [BIT_HEIGHT-1:0] cfg_y0,
  input  logic [BIT_HEIGHT-1:0] cfg_height,
  input  logic [BIT_WIDTH-1:0]  cx,
  input  logic [BIT_HEIGHT-1:0] cy,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [23:0]           rgb,
  output logic                  rgb_active,
  output logic                  frame_req,
  output logic                  frame_done,
  output logic                  frame_error,
  output logic                  underflow_sticky,
  input  logic                  underflow_clear,
  output logic [1:0]            state_o
);

  localparam int CNT_W = BIT_WIDTH + BIT_HEIGHT;
  localparam logic [BIT_WIDTH:0]  SCREEN_W_L = (BIT_WIDTH + 1)'(SCREEN_WIDTH);
  localparam logic [BIT_HEIGHT:0] SCREEN_H_L = (BIT_HEIGHT + 1)'(SCREEN_HEIGHT);
  localparam logic [BIT_WIDTH-1:0]  BOUND_X  = BIT_WIDTH'(FRAME_WIDTH - 1);
  localparam logic [BIT_HEIGHT-1:0] BOUND_Y  = BIT_HEIGHT'(FRAME_HEIGHT - 1 - IMAGE_CHANGE_TIME);

  sender_state_e         state;
  pixel_mode_e           sh_mode;
  logic [BIT_WIDTH-1:0]  sh_x0;
  logic [BIT_WIDTH-1:0]  sh_w;
  logic [BIT_HEIGHT-1:0] sh_y0;
  logic [BIT_HEIGHT-1:0] sh_h;
  logic                  change_pending;
  logic                  frame_uf;
  logic [CNT_W-1:0]      pix_cnt;
  logic [CNT_W-1:0]      win_area;
  logic                  boundary;
  logic                  cfg_ok;
  logic                  in_window;
  logic                  underflow;
  logic [23:0]           pixel;
  logic [BIT_WIDTH:0]    cfg_x_end;
  logic [BIT_HEIGHT:0]   cfg_y_end;
  logic [BIT_WIDTH:0]    x_end;
  logic [BIT_HEIGHT:0]   y_end;
  logic [23:0]           rgb_p1;
  logic                  vld_p1;

  assign boundary  = (cx == BOUND_X) && (cy == BOUND_Y);

  // Extra top bit on the window ends so x0+w / y0+h cannot wrap
  assign cfg_x_end = {1'b0, cfg_x0} + {1'b0, cfg_width};
  assign cfg_y_end = {1'b0, cfg_y0} + {1'b0, cfg_height};
  assign cfg_ok    = (pixel_mode_e'(cfg_mode) != MODE_RSVD) &&
                     (cfg_width != '0) && (cfg_height != '0) &&
                     (cfg_x_end <= SCREEN_W_L) && (cfg_y_end <= SCREEN_H_L);

  assign x_end     = {1'b0, sh_x0} + {1'b0, sh_w};
  assign y_end     = {1'b0, sh_y0} + {1'b0, sh_h};
  assign in_window = (state == ST_ACTIVE) &&
                     (cx >= sh_x0) && ({1'b0, cx} < x_end) &&
                     (cy >= sh_y0) && ({1'b0, cy} < y_end);
  assign win_area  = CNT_W'(sh_w) * CNT_W'(sh_h);

  pixel_unpacker #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_unpacker (
    .clk_pixel            (clk_pixel),
    .image_sender_reset_n (image_sender_reset_n),
    .active               (state == ST_ACTIVE),
    .consume              (in_window),
    .flush                (boundary),
    .mode                 (sh_mode),
    .s_data               (s_data),
    .s_valid              (s_valid),
    .s_ready              (s_ready),
    .pixel                (pixel),
    .underflow            (underflow)
  );

  // Frame control: FSM, boundary pulses, shadow config, pixel accounting, sticky flag
  always_ff @(posedge clk_pixel) begin
    if (!image_sender_reset_n) begin
      state            <= ST_IDLE;
      frame_req        <= 1'b0;
      frame_done       <= 1'b0;
      frame_error      <= 1'b0;
      change_pending   <= 1'b0;
      frame_uf         <= 1'b0;
      pix_cnt          <= '0;
      underflow_sticky <= 1'b0;
      sh_mode          <= MODE_MONO8;
      sh_x0            <= '0;
      sh_w             <= '0;
      sh_y0            <= '0;
      sh_h             <= '0;
    end else begin
      frame_req   <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      if (underflow) underflow_sticky <= 1'b1;
      else if (underflow_clear) underflow_sticky <= 1'b0;
      if (boundary) begin
        // A change request landing on the boundary itself belongs to the next frame
        change_pending <= image_change;
        sh_mode        <= pixel_mode_e'(cfg_mode);
        sh_x0          <= cfg_x0;
        sh_w           <= cfg_width;
        sh_y0          <= cfg_y0;
        sh_h           <= cfg_height;
        pix_cnt        <= '0;
        frame_uf       <= 1'b0;
        case (state)
          ST_IDLE: begin
            if (enable) begin
              if (cfg_ok) begin
                state     <= ST_ACTIVE;
                frame_req <= 1'b1;
              end else begin
                frame_error <= 1'b1;
              end
            end
          end
          default: begin
            frame_done  <= 1'b1;
            frame_error <= (pix_cnt != win_area) || frame_uf || (enable && !cfg_ok);
            if (enable && cfg_ok) frame_req <= change_pending;
            else state <= ST_IDLE;
          end
        endcase
      end else begin
        if (image_change) change_pending <= 1'b1;
        if (in_window) pix_cnt <= pix_cnt + CNT_W'(1);
        if (underflow) frame_uf <= 1'b1;
      end
    end
  end

  // Output stage p1: colour and window flag registered one cycle after cx/cy
  always_ff @(posedge clk_pixel) begin
    if (!image_sender_reset_n) begin
      rgb_p1 <= RESET_COLOR;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= in_window;
      if (in_window) rgb_p1 <= underflow ? UNDERFLOW_COLOR : pixel;
      else if (state == ST_ACTIVE) rgb_p1 <= BG_COLOR;
      else rgb_p1 <= IDLE_COLOR;
    end
  end

  assign rgb        = rgb_p1;
  assign rgb_active = vld_p1;
  assign state_o    = state;

endmodule

// File: tb/tb_image_window_sender.sv
// Directed bench for image_window_sender: coordinates are driven directly,
// jumping between the window, idle spots and the frame boundary.
module tb_image_window_sender;

  localparam int BX = 2199;
  localparam int BY = 1084;

  logic         clk_pixel = 1'b0;
  logic         image_sender_reset_n;
  logic         enable;
  logic         image_change;
  logic [1:0]   cfg_mode;
  logic [11:0]  cfg_x0, cfg_width, cx;
  logic [10:0]  cfg_y0, cfg_height, cy;
  logic [127:0] s_data;
  logic         s_valid;
  logic         s_ready;
  logic [23:0]  rgb;
  logic         rgb_active;
  logic         frame_req, frame_done, frame_error;
  logic         underflow_sticky;
  logic         underflow_clear;
  logic [1:0]   state_o;

  int checks = 0;
  int errors = 0;

  logic [127:0] w8, w1, w32;
  logic [7:0]   b;
  logic [23:0]  rgbx_exp [4];

  always #5 clk_pixel = ~clk_pixel;

  image_window_sender dut (
    .clk_pixel            (clk_pixel),
    .image_sender_reset_n (image_sender_reset_n),
    .enable               (enable),
    .image_change         (image_change),
    .cfg_mode             (cfg_mode),
    .cfg_x0               (cfg_x0),
    .cfg_width            (cfg_width),
    .cfg_y0               (cfg_y0),
    .cfg_height           (cfg_height),
    .cx                   (cx),
    .cy                   (cy),
    .s_data               (s_data),
    .s_valid              (s_valid),
    .s_ready              (s_ready),
    .rgb                  (rgb),
    .rgb_active           (rgb_active),
    .frame_req            (frame_req),
    .frame_done           (frame_done),
    .frame_error          (frame_error),
    .underflow_sticky     (underflow_sticky),
    .underflow_clear      (underflow_clear),
    .state_o              (state_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int x, input int y);
    cx = 12'(x);
    cy = 11'(y);
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic set_cfg(input logic [1:0] m, input int x0, input int y0, input int w, input int h);
    cfg_mode   = m;
    cfg_x0     = 12'(x0);
    cfg_y0     = 11'(y0);
    cfg_width  = 12'(w);
    cfg_height = 11'(h);
  endtask

  task automatic boundary_chk(input string tag, input logic req, input logic done, input logic err);
    tick(BX, BY);
    chk({tag, "_req"},  32'(frame_req),   32'(req));
    chk({tag, "_done"}, 32'(frame_done),  32'(done));
    chk({tag, "_err"},  32'(frame_error), 32'(err));
  endtask

  initial begin
    image_sender_reset_n = 1'b0;
    enable = 1'b0; image_change = 1'b0; underflow_clear = 1'b0;
    s_valid = 1'b0; s_data = '0;
    set_cfg(2'd0, 0, 0, 0, 0);
    cx = '0; cy = '0;
    w8 = '0;
    for (int i = 0; i < 16; i++) w8[i*8 +: 8] = 8'(i);
    w1  = 128'h5;
    w32 = {32'hAA112233, 32'hBB445566, 32'hCC778899, 32'hDDABCDEF};
    rgbx_exp[0] = 24'hABCDEF; rgbx_exp[1] = 24'h778899;
    rgbx_exp[2] = 24'h445566; rgbx_exp[3] = 24'h112233;

    // Reset state
    tick(0, 0); tick(0, 0);
    chk("rst_state",  32'(state_o),          32'd0);
    chk("rst_rgb",    32'(rgb),              32'hFFFFFF);
    chk("rst_act",    32'(rgb_active),       32'd0);
    chk("rst_ready",  32'(s_ready),          32'd0);
    chk("rst_req",    32'(frame_req),        32'd0);
    chk("rst_done",   32'(frame_done),       32'd0);
    chk("rst_err",    32'(frame_error),      32'd0);
    chk("rst_sticky", 32'(underflow_sticky), 32'd0);

    // Frame A: MONO8 4x2 window at (958,539)
    image_sender_reset_n = 1'b1;
    enable = 1'b1;
    set_cfg(2'd0, 958, 539, 4, 2);
    tick(0, 0);
    chk("idle_color", 32'(rgb), 32'h0000FF);
    boundary_chk("start", 1'b1, 1'b0, 1'b0);
    chk("start_state", 32'(state_o), 32'd1);
    tick(0, 0);
    chk("req_one_pulse", 32'(frame_req), 32'd0);
    chk("bg_color",      32'(rgb),       32'hFF0000);
    s_valid = 1'b1; s_data = w8; #1;
    chk("ready_empty", 32'(s_ready), 32'd1);
    tick(1, 0);
    s_valid = 1'b0; #1;
    chk("ready_full", 32'(s_ready), 32'd0);
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) begin
        tick(958 + c, 539 + r);
        b = 8'(r * 4 + c);
        chk("mono8_act", 32'(rgb_active), 32'd1);
        chk("mono8_rgb", 32'(rgb), {8'h00, b, b, b});
      end
    end
    tick(962, 539);
    chk("right_of_win_act", 32'(rgb_active), 32'd0);
    chk("right_of_win_rgb", 32'(rgb),        32'hFF0000);
    set_cfg(2'd2, 958, 539, 4, 2);
    boundary_chk("endA", 1'b0, 1'b1, 1'b0);

    // Frame B: MONO1, image_change mid-frame, next config staged mid-frame
    s_valid = 1'b1; s_data = w1;
    tick(0, 0);
    s_valid = 1'b0;
    image_change = 1'b1;
    tick(5, 0);
    image_change = 1'b0;
    set_cfg(2'd1, 100, 10, 4, 1);
    tick(100, 10);
    chk("cfg_shadow_hold", 32'(rgb_active), 32'd0);
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) begin
        tick(958 + c, 539 + r);
        chk("mono1_rgb", 32'(rgb), (r == 0 && (c % 2) == 0) ? 32'hFFFFFF : 32'h000000);
      end
    end
    boundary_chk("endB", 1'b1, 1'b1, 1'b0);

    // Frame C: RGBX32 4x1 window at (100,10); image_change on the boundary cycle
    s_valid = 1'b1; s_data = w32;
    tick(0, 0);
    s_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin
        cx = 12'd103; cy = 11'd10; #1;
        chk("ready_last_slot", 32'(s_ready), 32'd1);
      end
      tick(100 + c, 10);
      chk("rgbx_rgb", 32'(rgb), {8'h00, rgbx_exp[c]});
    end
    set_cfg(2'd0, 10, 5, 3, 2);
    image_change = 1'b1;
    boundary_chk("endC", 1'b0, 1'b1, 1'b0);
    image_change = 1'b0;

    // Frame D: MONO8 3x2 at (10,5); first row starved, word arrives between rows
    for (int c = 0; c < 3; c++) begin
      underflow_clear = (c == 1);
      tick(10 + c, 5);
      underflow_clear = 1'b0;
      chk("uf_rgb",    32'(rgb),              32'h00FF00);
      chk("uf_sticky", 32'(underflow_sticky), 32'd1);
    end
    s_valid = 1'b1; s_data = w8;
    tick(13, 5);
    s_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick(10 + c, 6);
      b = 8'(3 + c);
      chk("late_word_rgb", 32'(rgb), {8'h00, b, b, b});
    end
    boundary_chk("endD", 1'b1, 1'b1, 1'b1);

    // Frame E: clean frame, enable dropped mid-frame, invalid config staged
    underflow_clear = 1'b1;
    tick(0, 0);
    underflow_clear = 1'b0;
    chk("uf_clear", 32'(underflow_sticky), 32'd0);
    s_valid = 1'b1; s_data = w8;
    tick(1, 0);
    s_valid = 1'b0;
    for (int c = 0; c < 3; c++) tick(10 + c, 5);
    enable = 1'b0;
    tick(10, 6);
    chk("en_low_act",   32'(rgb_active), 32'd1);
    chk("en_low_state", 32'(state_o),    32'd1);
    tick(11, 6); tick(12, 6);
    set_cfg(2'd0, 1917, 5, 4, 2);
    boundary_chk("endE", 1'b0, 1'b1, 1'b0);
    chk("endE_state", 32'(state_o), 32'd0);

    // Frame F: idle, enable with x0+w=1921 refused
    enable = 1'b1;
    tick(10, 5);
    chk("idle_win_act", 32'(rgb_active), 32'd0);
    chk("idle_win_rgb", 32'(rgb),        32'h0000FF);
    boundary_chk("bad_cfg", 1'b0, 1'b0, 1'b1);
    chk("bad_cfg_state", 32'(state_o), 32'd0);
    tick(0, 0);
    chk("bad_cfg_rgb", 32'(rgb), 32'h0000FF);
    set_cfg(2'd0, 10, 5, 3, 2);
    boundary_chk("restart", 1'b1, 1'b0, 1'b0);

    // Frame G: reset in the middle of the window
    s_valid = 1'b1; s_data = w8;
    tick(0, 0);
    tick(10, 5);
    chk("pre_rst_act", 32'(rgb_active), 32'd1);
    chk("pre_rst_rgb", 32'(rgb),        32'h000000);
    image_sender_reset_n = 1'b0;
    tick(11, 5);
    chk("mid_rst_rgb",   32'(rgb),        32'hFFFFFF);
    chk("mid_rst_act",   32'(rgb_active), 32'd0);
    chk("mid_rst_state", 32'(state_o),    32'd0);
    chk("mid_rst_ready", 32'(s_ready),    32'd0);
    image_sender_reset_n = 1'b1;
    s_valid = 1'b0;
    tick(BX, BY);
    chk("no_done_after_rst", 32'(frame_done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
